// File: rtl/apb_pkg.sv
// Shared APB completer definitions.
//   apb_state_e     : completer transfer FSM states (IDLE, ACCESS)
//   APB_DATA_W      : APB data bus width (32)
//   APB_STRB_W      : APB write strobe width (4)
//   apb_merge_bytes : merges new write data into an old word per byte strobe
package apb_pkg;

    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    function automatic logic [APB_DATA_W-1:0] apb_merge_bytes(
        input logic [APB_DATA_W-1:0] old_word,
        input logic [APB_DATA_W-1:0] new_data,
        input logic [APB_STRB_W-1:0] strb
    );
        logic [APB_DATA_W-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < APB_STRB_W; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable wait-state down-counter for APB completers.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one (saturates at zero)
//   last     : count is exactly one, i.e. the next decrement ends the wait
module apb_wait_ctr #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer with a DEPTH x 32-bit byte-strobed register memory and a
// fixed number of wait states per access phase. Out-of-range or misaligned
// accesses complete with PSLVERR and have no effect.
// Optional feature (macro APB_SLV_PROT_EN): adds PPROT; writes to the upper
// half of memory require PPROT[0]=1, otherwise they fail with PSLVERR.
// Ports:
//   PCLK, PRESET        : clock, asynchronous active-high reset
//   PSEL, PENABLE       : APB select / access-phase indicator
//   PWRITE, PADDR       : direction and byte address
//   PWDATA, PSTRB       : write data and byte lane enables
//   PPROT               : protection attributes (only with APB_SLV_PROT_EN)
//   PRDATA, PREADY,
//   PSLVERR             : registered response
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [APB_DATA_W-1:0] PWDATA,
    input  logic [APB_STRB_W-1:0] PSTRB,
`ifdef APB_SLV_PROT_EN
    input  logic [2:0]            PPROT,
`endif
    output logic [APB_DATA_W-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned         IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0]   ADDR_LIMIT = ADDR_W'(DEPTH * 4);
    localparam logic [3:0]          WAIT_INIT  = 4'(WAIT_CYCLES);

    apb_state_e state, next_state;

    logic [APB_DATA_W-1:0] mem [DEPTH];

    logic                  err_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic [APB_DATA_W-1:0] wdata_q;
    logic [APB_STRB_W-1:0] strb_q;

    logic                  setup_err;
    logic [IDX_W-1:0]      setup_idx;
    logic                  xfer_err;
    logic [IDX_W-1:0]      xfer_idx;
    logic                  xfer_write;
    logic [APB_DATA_W-1:0] resp_data;

    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_last;
    logic                  commit;
    logic                  pready_d;
    logic                  pslverr_d;
    logic [APB_DATA_W-1:0] prdata_d;

    // Decode of the live setup-phase address.
    always_comb begin
        setup_idx = PADDR[IDX_W+1:2];
        setup_err = (PADDR >= ADDR_LIMIT) || (PADDR[1:0] != 2'b00);
`ifdef APB_SLV_PROT_EN
        if (PWRITE && (32'(setup_idx) >= (DEPTH / 2)) && !PPROT[0]) begin
            setup_err = 1'b1;
        end
`endif
    end

    // With zero wait states the response is produced on the setup edge, before
    // the latched copies exist, so the live setup values are used in IDLE.
    always_comb begin
        xfer_err   = (state == IDLE) ? setup_err : err_q;
        xfer_idx   = (state == IDLE) ? setup_idx : idx_q;
        xfer_write = (state == IDLE) ? PWRITE    : write_q;
        resp_data  = (!xfer_write && !xfer_err) ? mem[xfer_idx] : '0;
    end

    apb_wait_ctr #(
        .CNT_W (4)
    ) u_wait_ctr (
        .clk      (PCLK),
        .rst      (PRESET),
        .load     (cnt_load),
        .load_val (WAIT_INIT),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        commit     = 1'b0;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        prdata_d   = '0;
        unique case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    cnt_load   = 1'b1;
                    next_state = ACCESS;
                    if (WAIT_CYCLES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = xfer_err;
                        prdata_d  = resp_data;
                    end
                end
            end
            ACCESS: begin
                if (PREADY) begin
                    commit     = write_q && !err_q;
                    next_state = IDLE;
                end else if (PSEL) begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        pready_d  = 1'b1;
                        pslverr_d = xfer_err;
                        prdata_d  = resp_data;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            PREADY  <= pready_d;
            PSLVERR <= pslverr_d;
            PRDATA  <= prdata_d;
            if (cnt_load) begin
                err_q   <= setup_err;
                idx_q   <= setup_idx;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
            end
            if (commit) begin
                mem[idx_q] <= apb_merge_bytes(mem[idx_q], wdata_q, strb_q);
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with WAIT_CYCLES=1 and one
// with WAIT_CYCLES=0 sharing the bus signals, each with its own PSEL.
// Define APB_SLV_PROT_EN for both RTL and bench to cover the privilege check.
module tb_apb_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel0, psel1, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
`ifdef APB_SLV_PROT_EN
    logic [2:0]  pprot;
`endif
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] rd;
    logic        er;
    int unsigned rc, tc;

    always #5 clk = ~clk;

    apb_slave_mem #(.ADDR_W(32), .DEPTH(16), .WAIT_CYCLES(1)) u_dut0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
`ifdef APB_SLV_PROT_EN
        .PPROT(pprot),
`endif
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_slave_mem #(.ADDR_W(32), .DEPTH(16), .WAIT_CYCLES(0)) u_dut1 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel1), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
`ifdef APB_SLV_PROT_EN
        .PPROT(pprot),
`endif
        .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge. Returns the response, the
    // access cycle in which PREADY was seen, and the edges the transfer spanned.
    task automatic apb_xfer(input int unsigned dut, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb,
                            output logic [31:0] rdata, output logic err,
                            output int unsigned ready_cyc, output int unsigned total_cyc);
        logic rdy;
        psel0   = (dut == 0);
        psel1   = (dut == 1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        @(posedge clk); #1;
        total_cyc = 1;
        penable   = 1'b1;
        paddr     = addr ^ 32'h4;
        pwdata    = ~data;
        ready_cyc = 0;
        rdata     = '0;
        err       = 1'b0;
        rdy       = 1'b0;
        for (int unsigned c = 1; c <= 20; c++) begin
            rdy = (dut == 1) ? pready1 : pready0;
            if (rdy) begin
                ready_cyc = c;
                rdata = (dut == 1) ? prdata1 : prdata0;
                err   = (dut == 1) ? pslverr1 : pslverr0;
                break;
            end
            @(posedge clk); #1;
            total_cyc++;
        end
        check_eq("ready_seen", {31'b0, rdy}, 32'd1);
        @(posedge clk); #1;
        total_cyc++;
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        pstrb   = '0;
        check_eq("post_ready", {31'b0, (dut == 1) ? pready1 : pready0}, 32'd0);
        check_eq("post_rdata", (dut == 1) ? prdata1 : prdata0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
`ifdef APB_SLV_PROT_EN
        pprot = 3'b000;
`endif
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst_ready0", {31'b0, pready0}, 32'd0);
        check_eq("rst_err0",   {31'b0, pslverr0}, 32'd0);
        check_eq("rst_rdata0", prdata0, 32'd0);
        check_eq("rst_ready1", {31'b0, pready1}, 32'd0);
        check_eq("rst_rdata1", prdata1, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-word write then readback, PREADY in access cycle 2.
        apb_xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, rd, er, rc, tc);
        check_eq("wr04_err", {31'b0, er}, 32'd0);
        check_eq("wr04_rcyc", rc, 32'd2);
        check_eq("wr04_total", tc, 32'd3);
        apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("rd04_data", rd, 32'hDEADBEEF);
        check_eq("rd04_err", {31'b0, er}, 32'd0);
        check_eq("rd04_rcyc", rc, 32'd2);

        // Partial strobe write.
        apb_xfer(0, 1'b1, 32'h08, 32'h11223344, 4'h5, rd, er, rc, tc);
        check_eq("wr08_err", {31'b0, er}, 32'd0);
        apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("rd08_data", rd, 32'h00220044);

        // Out-of-range and misaligned accesses.
        apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("rd40_err", {31'b0, er}, 32'd1);
        check_eq("rd40_data", rd, 32'd0);
        check_eq("rd40_rcyc", rc, 32'd2);
        apb_xfer(0, 1'b1, 32'h41, 32'hFFFFFFFF, 4'hF, rd, er, rc, tc);
        check_eq("wr41_err", {31'b0, er}, 32'd1);
        apb_xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("rd00_data", rd, 32'd0);
        apb_xfer(0, 1'b1, 32'h06, 32'h0, 4'hF, rd, er, rc, tc);
        check_eq("wr06_err", {31'b0, er}, 32'd1);
        apb_xfer(0, 1'b0, 32'h3C, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("rd3c_err", {31'b0, er}, 32'd0);

        // Zero strobe write leaves memory untouched.
        apb_xfer(0, 1'b1, 32'h04, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("wr04s0_err", {31'b0, er}, 32'd0);
        apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("rd04_keep", rd, 32'hDEADBEEF);

        // Master drops PSEL during ACCESS: no write.
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        psel0 = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_ready", {31'b0, pready0}, 32'd0);
        apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("rd10_abort", rd, 32'd0);

        // Zero wait states, back-to-back.
        apb_xfer(1, 1'b1, 32'h00, 32'h1, 4'hF, rd, er, rc, tc);
        check_eq("w0_wr_rcyc", rc, 32'd1);
        check_eq("w0_wr_total", tc, 32'd2);
        apb_xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("w0_rd_data", rd, 32'h1);
        check_eq("w0_rd_rcyc", rc, 32'd1);
        check_eq("w0_rd_total", tc, 32'd2);
        apb_xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("w0_rd40_err", {31'b0, er}, 32'd1);

`ifdef APB_SLV_PROT_EN
        pprot = 3'b000;
        apb_xfer(0, 1'b1, 32'h20, 32'hAA, 4'hF, rd, er, rc, tc);
        check_eq("prot0_err", {31'b0, er}, 32'd1);
        apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("prot0_rd", rd, 32'd0);
        check_eq("prot0_rderr", {31'b0, er}, 32'd0);
        pprot = 3'b001;
        apb_xfer(0, 1'b1, 32'h20, 32'hAA, 4'hF, rd, er, rc, tc);
        check_eq("prot1_err", {31'b0, er}, 32'd0);
        apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("prot1_rd", rd, 32'hAA);
        pprot = 3'b000;
`endif

        // Reset while PREADY is high on a write: aborts the write.
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h0C; pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_pre_ready", {31'b0, pready0}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_ready", {31'b0, pready0}, 32'd0);
        check_eq("rst_mid_err", {31'b0, pslverr0}, 32'd0);
        check_eq("rst_mid_rdata", prdata0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        apb_xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("rd0c_after_rst", rd, 32'd0);
        apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, rc, tc);
        check_eq("rd04_after_rst", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
